// File: rtl/grid_scanner_pkg.sv
// grid_scan_pkg: shared FSM state enum and state width for grid_scanner.
// No ports; imported by grid_scanner.
package grid_scan_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/grid_scanner_if.sv
// grid_scanner_if: coordinate stream handshake (valid/ready/x/y/last).
// master drives valid,x,y,last and samples ready; slave is the consumer.
interface grid_scanner_if #(
  parameter int X_WIDTH = 4,
  parameter int Y_WIDTH = 4
);

  logic               valid;
  logic               ready;
  logic               last;
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;

  modport master (
    output valid, x, y, last,
    input  ready
  );

  modport slave (
    input  valid, x, y, last,
    output ready
  );

endinterface

// File: rtl/grid_scanner_axis_counter.sv
// scan_axis_counter: wrapping 0..MAX-1 index counter for one grid axis.
// Ports: clk, rst_n, clr (to 0), inc (advance), v (index), wrap (v==MAX-1).
module scan_axis_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] v,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] r_v;

  // wrap flags the terminal index, so the owner can chain axes
  assign wrap = (r_v == LAST);
  assign v    = r_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else if (clr) begin
      r_v <= '0;
    end else if (inc) begin
      if (wrap) r_v <= '0;
      else      r_v <= r_v + 1'b1;
    end
  end

endmodule

// File: rtl/grid_scanner.sv
// grid_scanner: raster-scans an X_MAX x Y_MAX grid, one coordinate per beat.
// Ports: clk, rst_n, start, bus (valid/ready/x/y/last), done, busy;
// optional abort when GRID_SCANNER_ABORT_EN is defined.
module grid_scanner
  import grid_scan_pkg::*;
#(
  parameter int X_WIDTH = 4,
  parameter int Y_WIDTH = 4,
  parameter int X_MAX   = 3,
  parameter int Y_MAX   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
`ifdef GRID_SCANNER_ABORT_EN
  input  logic           abort,
`endif
  grid_scanner_if.master bus,
  output logic           done,
  output logic           busy
);

  state_t r_state;
  state_t w_state_nxt;

  logic               w_clr;
  logic               w_beat;
  logic               w_adv;
  logic               w_abort;
  logic               w_x_wrap;
  logic               w_y_wrap;
  logic [X_WIDTH-1:0] w_x;
  logic [Y_WIDTH-1:0] w_y;

`ifdef GRID_SCANNER_ABORT_EN
  assign w_abort = abort && (r_state == SCAN);
`else
  assign w_abort = 1'b0;
`endif

  assign w_beat = bus.valid && bus.ready;
  // abort wins over a same-cycle beat
  assign w_adv  = w_beat && !w_abort;

  scan_axis_counter #(
    .WIDTH (X_WIDTH),
    .MAX   (X_MAX)
  ) u_x (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_adv),
    .v     (w_x),
    .wrap  (w_x_wrap)
  );

  scan_axis_counter #(
    .WIDTH (Y_WIDTH),
    .MAX   (Y_MAX)
  ) u_y (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_clr),
    .inc   (w_adv && w_x_wrap),
    .v     (w_y),
    .wrap  (w_y_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SCAN;
          w_clr       = 1'b1;
        end
      end
      SCAN: begin
        if (w_abort) begin
          w_state_nxt = IDLE;
          w_clr       = 1'b1;
        end else if (w_adv && w_x_wrap && w_y_wrap) begin
          // both counters wrap back to 0 on this beat
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_state_nxt = SCAN;
          w_clr       = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_clr       = 1'b1;
      end
    endcase
  end

  assign bus.valid = (r_state == SCAN);
  assign bus.x     = w_x;
  assign bus.y     = w_y;
  assign bus.last  = bus.valid && w_x_wrap && w_y_wrap;
  assign busy      = (r_state == SCAN);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_grid_scanner.sv
// tb_grid_scanner: random/directed stimulus vs a raster-order model.
// Drives a 3x2 and a 1x1 grid_scanner; abort cases with GRID_SCANNER_ABORT_EN.
module tb_grid_scanner;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic done, busy, done1, busy1;
`ifdef GRID_SCANNER_ABORT_EN
  logic abort  = 1'b0;
  logic abort1 = 1'b0;
`endif

  grid_scanner_if #(.X_WIDTH(4), .Y_WIDTH(4)) bus ();
  grid_scanner_if #(.X_WIDTH(4), .Y_WIDTH(4)) bus1 ();

  grid_scanner #(
    .X_WIDTH(4), .Y_WIDTH(4), .X_MAX(3), .Y_MAX(2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
`ifdef GRID_SCANNER_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus.master),
    .done  (done),
    .busy  (busy)
  );

  grid_scanner #(
    .X_WIDTH(4), .Y_WIDTH(4), .X_MAX(1), .Y_MAX(1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
`ifdef GRID_SCANNER_ABORT_EN
    .abort (abort1),
`endif
    .bus   (bus1.master),
    .done  (done1),
    .busy  (busy1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int xq[$];
  int yq[$];
  localparam int NCELL = 6;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(string tag);
    chk({tag, "_valid"}, 32'(bus.valid), 0);
    chk({tag, "_busy"},  32'(busy),      0);
    chk({tag, "_done"},  32'(done),      0);
    chk({tag, "_last"},  32'(bus.last),  0);
    chk({tag, "_x"},     32'(bus.x),     0);
    chk({tag, "_y"},     32'(bus.y),     0);
  endtask

  // mode 0: ready=1, 1: stall 4 cycles at cell 1, 2: random ready,
  // 3: ready=1 with a stray start at cell 2
  task automatic run_scan(input int mode, output int beats);
    int idx   = 0;
    int stall = 0;
    beats = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_on", 32'(busy), 1);
    for (int g = 0; g < 200 && idx < NCELL; g++) begin
      chk("valid", 32'(bus.valid), 1);
      chk("x", 32'(bus.x), 32'(xq[idx]));
      chk("y", 32'(bus.y), 32'(yq[idx]));
      chk("last", 32'(bus.last), 32'(idx == NCELL - 1));
      chk("done_lo", 32'(done), 0);
      case (mode)
        1: begin
          if (idx == 1 && stall < 4) begin
            bus.ready = 1'b0;
            stall++;
          end else begin
            bus.ready = 1'b1;
          end
        end
        2: bus.ready = 1'($urandom_range(0, 1));
        3: begin
          bus.ready = 1'b1;
          start = (idx == 2);
        end
        default: bus.ready = 1'b1;
      endcase
      if (bus.valid && bus.ready) beats++;
      if (bus.ready) idx++;
      tick();
      start = 1'b0;
    end
    if (idx < NCELL) chk("scan_timeout", 32'(idx), 32'(NCELL));
    chk("end_done", 32'(done), 1);
    chk("end_valid", 32'(bus.valid), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_x", 32'(bus.x), 0);
    chk("end_y", 32'(bus.y), 0);
    bus.ready = 1'b0;
    tick();
    chk("post_done", 32'(done), 0);
    chk("post_valid", 32'(bus.valid), 0);
  endtask

  initial begin
    int nb;
    bus.ready  = 1'b0;
    bus1.ready = 1'b0;
    for (int yy = 0; yy < 2; yy++)
      for (int xx = 0; xx < 3; xx++) begin
        xq.push_back(xx);
        yq.push_back(yy);
      end

    #3;
    chk_quiet("rst");
    #9 rst_n = 1'b1;
    tick();
    chk_quiet("idle");

    run_scan(0, nb);
    chk("beats_basic", 32'(nb), 6);
    run_scan(1, nb);
    chk("beats_stall", 32'(nb), 6);
    run_scan(3, nb);
    chk("beats_start", 32'(nb), 6);
    for (int r = 0; r < 4; r++) begin
      run_scan(2, nb);
      chk("beats_rand", 32'(nb), 6);
    end

    // reset mid-scan at (2,0)
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.ready = 1'b1;
    tick();
    tick();
    bus.ready = 1'b0;
    chk("pre_rst_x", 32'(bus.x), 2);
    #1 rst_n = 1'b0;
    #1;
    chk_quiet("async_rst");
    #1 rst_n = 1'b1;
    bus.ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_quiet("no_resume");
    end
    bus.ready = 1'b0;
    run_scan(0, nb);
    chk("beats_after_rst", 32'(nb), 6);

    // 1x1 grid
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("g1_valid", 32'(bus1.valid), 1);
    chk("g1_x", 32'(bus1.x), 0);
    chk("g1_y", 32'(bus1.y), 0);
    chk("g1_last", 32'(bus1.last), 1);
    bus1.ready = 1'b1;
    tick();
    bus1.ready = 1'b0;
    chk("g1_done", 32'(done1), 1);
    chk("g1_valid_lo", 32'(bus1.valid), 0);
    tick();
    chk("g1_done_lo", 32'(done1), 0);
    chk("g1_busy_lo", 32'(busy1), 0);

`ifdef GRID_SCANNER_ABORT_EN
    // abort with a same-cycle beat at (1,1)
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("ab_x", 32'(bus.x), 1);
    chk("ab_y", 32'(bus.y), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_quiet("abort");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_quiet("abort_idle");
    end
    // abort is ignored in IDLE
    bus.ready = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("ab_idle_start", 32'(bus.valid), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_quiet("abort2");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_scanner.md
GRID_SCANNER -- requirements
Module: grid_scanner

Interface
REQ-001 The block SHALL have parameter X_WIDTH, default 4: width of the column index.
REQ-002 The block SHALL have parameter Y_WIDTH, default 4: width of the row index.
REQ-003 The block SHALL have parameter X_MAX, default 3: column count, legal range 1..2**X_WIDTH.
REQ-004 The block SHALL have parameter Y_MAX, default 2: row count, legal range 1..2**Y_WIDTH.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: request a new full-grid scan.
REQ-008 The block SHALL have port ready, input, 1 bit: the consumer accepts the current coordinate.
REQ-009 The block SHALL have port x, output, X_WIDTH bits: current column.
REQ-010 The block SHALL have port y, output, Y_WIDTH bits: current row.
REQ-011 The block SHALL have port valid, output, 1 bit: x and y carry a live coordinate.
REQ-012 The block SHALL have port last, output, 1 bit: the current coordinate is the final grid cell.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle scan-complete pulse.
REQ-014 The block SHALL have port busy, output, 1 bit: the FSM is in SCAN.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, SCAN and DONE, and SHALL be in IDLE after reset.
REQ-016 In IDLE or DONE, start=1 SHALL, at the next edge, enter SCAN with x=0 and y=0 and drive valid=1; latency from start to the first valid is one cycle.
REQ-017 start SHALL be ignored while in SCAN.
REQ-018 A beat SHALL occur only when valid=1 and ready=1 in the same cycle.
REQ-019 While valid=1 and ready=0, x, y and last SHALL hold stable.
REQ-020 On a beat with x!=X_MAX-1, x SHALL increment by 1 and y SHALL hold.
REQ-021 On a beat with x==X_MAX-1 and y!=Y_MAX-1, x SHALL wrap to 0 and y SHALL increment by 1.
REQ-022 On a beat with x==X_MAX-1 and y==Y_MAX-1, the FSM SHALL enter DONE, valid SHALL fall, and x and y SHALL return to 0.
REQ-023 last SHALL equal valid AND x==X_MAX-1 AND y==Y_MAX-1.
REQ-024 done SHALL be 1 for exactly the one cycle spent in DONE; DONE SHALL then go to IDLE, or to SCAN if start=1.
REQ-025 With X_MAX=1, x SHALL stay 0 and every beat SHALL advance y; with X_MAX=Y_MAX=1, the scan SHALL be one beat with last=1.
REQ-026 Index comparisons SHALL use constants sized to X_WIDTH or Y_WIDTH; no index SHALL ever exceed its MAX-1.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, x=0, y=0, valid=0, last=0, done=0 and busy=0, including in the middle of a scan.
REQ-028 After rst_n is released, the block SHALL require a fresh start before it scans again; there SHALL be no resume.

Configuration
REQ-029 With GRID_SCANNER_ABORT_EN defined, the block SHALL add an input port abort, 1 bit.
REQ-030 abort=1 in SCAN SHALL return the FSM to IDLE at the next edge with valid=0, x=0, y=0 and no done pulse.
REQ-031 abort SHALL take priority over a same-cycle beat.
REQ-032 abort SHALL be ignored in IDLE and DONE.
REQ-033 Without GRID_SCANNER_ABORT_EN, the abort port and its logic SHALL be absent, and the behaviour SHALL be REQ-015 to REQ-028 only.

Structure
REQ-034 Package grid_scan_pkg SHALL hold the state enum (IDLE, SCAN, DONE) and the state-width constant.
REQ-035 Sub-module scan_axis_counter SHALL implement one wrapping axis counter, with parameters WIDTH and MAX, inputs clk, rst_n, clr and inc, and outputs v and wrap.
REQ-036 grid_scanner SHALL instantiate scan_axis_counter twice: the x-axis wrap drives the y-axis inc, and the y-axis wrap qualifies the transition to DONE.

Verification
REQ-037 With X_MAX=3, Y_MAX=2, ready held at 1 and a 1-cycle start pulse, the bench SHALL check beats (0,0)(1,0)(2,0)(0,1)(1,1)(2,1), last=1 on the 6th beat only, and done=1 on the following cycle.
REQ-038 With ready=0 for 4 cycles while at (1,0), the bench SHALL check x=1, y=0 and valid=1 held for all 4 cycles, then the scan completing normally.
REQ-039 With start pulsed at (2,0) during SCAN, the bench SHALL check the scan is unaffected and exactly 6 beats occur.
REQ-040 With rst_n pulsed low at (2,0), the bench SHALL check all outputs are 0 within the same cycle, the FSM is in IDLE, and there is no activity until the next start.
REQ-041 With X_MAX=1 and Y_MAX=1, the bench SHALL check one beat (0,0) with last=1, followed by done.
REQ-042 With GRID_SCANNER_ABORT_EN defined, abort=1 and ready=1 at (1,1), the bench SHALL check that no beat is taken, the FSM is in IDLE next cycle, and done never asserts.
